// File: rtl/vote_pkg.sv
// Shared types, constants and helpers for the voting subsystem.
package vote_pkg;

    // Widest candidate vector the helper accepts; callers zero-extend.
    localparam int unsigned MAX_CAND  = 16;
    localparam int unsigned MAX_IDX_W = 4;

    localparam logic MODE_VOTE  = 1'b0;
    localparam logic MODE_TALLY = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        LOCKOUT = 2'd2
    } vote_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_CAND-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(MAX_CAND) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vote_debounce.sv
// Single-channel button debouncer producing one qualified pulse per press.
// Ports:
//   clock   - system clock
//   reset_n - asynchronous active-low reset
//   button  - raw button level
//   qual    - one-cycle pulse while the high-run counter equals DEBOUNCE_CYCLES
module vote_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic qual
);

    localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             qual_q;
    logic             qual_d;

    // Count consecutive high samples; the pulse is registered so it lines up
    // with the cycle in which the counter reads DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d  = '0;
        qual_d = 1'b0;
        if (button) begin
            if (cnt_q != CNT_W'(CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
            qual_d = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            qual_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            qual_q <= qual_d;
        end
    end

    assign qual = qual_q;

endmodule

// File: rtl/voting_machine_n.sv
// N-candidate voting machine: debounced buttons, one vote per press session,
// saturating counters, tally display and registered leader/tie flags.
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   mode           - 0 vote, 1 tally
//   button         - raw candidate buttons
//   clear_tally    - clears counters and saturated flag (tally mode only)
//   led            - LED bank (ack pattern or tally count)
//   vote_accepted  - pulse when a vote is recorded
//   vote_rejected  - pulse when a qualified press is discarded
//   leader_idx     - lowest index holding the maximum count
//   tie            - maximum shared by two or more candidates
//   saturated      - sticky overflow-attempt flag
module voting_machine_n
    import vote_pkg::*;
#(
    parameter int unsigned NUM_CAND        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned COUNT_W         = 8,
    parameter int unsigned ACK_CYCLES      = 10,
    parameter int unsigned IDX_W           = $clog2(NUM_CAND)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] button,
    input  logic                clear_tally,
    output logic [COUNT_W-1:0]  led,
    output logic                vote_accepted,
    output logic                vote_rejected,
    output logic [IDX_W-1:0]    leader_idx,
    output logic                tie,
    output logic                saturated
);

    localparam int unsigned ACK_W = $clog2(ACK_CYCLES + 1);

    logic [NUM_CAND-1:0] qual;

    vote_state_t                       state_q, state_d;
    logic [ACK_W-1:0]                  ack_cnt_q, ack_cnt_d;
    logic [COUNT_W-1:0]                led_q, led_d;
    logic                              acc_q, acc_d;
    logic                              rej_q, rej_d;
    logic [NUM_CAND-1:0][COUNT_W-1:0]  count_q, count_d;
    logic                              sat_q, sat_d;
    logic [IDX_W-1:0]                  leader_q, leader_d;
    logic                              tie_q, tie_d;

    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    btn_idx;
    logic                multi_qual;
    logic [COUNT_W-1:0]  max_v;
    logic [NUM_CAND-1:0] is_max;

    // Per-button debouncers.
    for (genvar i = 0; i < int'(NUM_CAND); i++) begin : g_deb
        vote_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock  (clock),
            .reset_n(reset_n),
            .button (button[i]),
            .qual   (qual[i])
        );
    end

    // Lowest qualified candidate wins; clearing its bit exposes any contender.
    assign cand       = IDX_W'(lowest_set_idx(MAX_CAND'(qual)));
    assign btn_idx    = IDX_W'(lowest_set_idx(MAX_CAND'(button)));
    assign multi_qual = |(qual & (qual - NUM_CAND'(1)));

    // Vote FSM, counters and LED mux.
    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        led_d     = led_q;
        acc_d     = 1'b0;
        rej_d     = 1'b0;
        count_d   = count_q;
        sat_d     = sat_q;

        if (mode == MODE_TALLY) begin
            state_d   = IDLE;
            ack_cnt_d = '0;
            if (clear_tally) begin
                count_d = '0;
                sat_d   = 1'b0;
                led_d   = '0;
            end else if (|button) begin
                led_d = count_q[btn_idx];
            end
        end else begin
            case (state_q)
                IDLE: begin
                    led_d = '0;
                    if (|qual) begin
                        if (count_q[cand] == {COUNT_W{1'b1}}) begin
                            sat_d = 1'b1;
                        end else begin
                            count_d[cand] = count_q[cand] + COUNT_W'(1);
                        end
                        acc_d     = 1'b1;
                        rej_d     = multi_qual;
                        state_d   = ACK;
                        ack_cnt_d = ACK_W'(ACK_CYCLES - 1);
                        led_d     = '1;
                    end
                end
                ACK: begin
                    rej_d = |qual;
                    if (ack_cnt_q == '0) begin
                        led_d   = '0;
                        state_d = (|button) ? LOCKOUT : IDLE;
                    end else begin
                        ack_cnt_d = ack_cnt_q - ACK_W'(1);
                        led_d     = '1;
                    end
                end
                LOCKOUT: begin
                    led_d = '0;
                    rej_d = |qual;
                    if (!(|button)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    led_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Leader/tie from the current counts, registered one cycle later.
    always_comb begin
        max_v = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (count_q[i] > max_v) begin
                max_v = count_q[i];
            end
        end
        is_max = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            is_max[i] = (count_q[i] == max_v);
        end
        leader_d = IDX_W'(lowest_set_idx(MAX_CAND'(is_max)));
        tie_d    = |(is_max & (is_max - NUM_CAND'(1)));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ack_cnt_q <= '0;
            led_q     <= '0;
            acc_q     <= 1'b0;
            rej_q     <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            leader_q  <= '0;
            tie_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
            led_q     <= led_d;
            acc_q     <= acc_d;
            rej_q     <= rej_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            leader_q  <= leader_d;
            tie_q     <= tie_d;
        end
    end

    assign led           = led_q;
    assign vote_accepted = acc_q;
    assign vote_rejected = rej_q;
    assign leader_idx    = leader_q;
    assign tie           = tie_q;
    assign saturated     = sat_q;

endmodule

// File: tb/tb_voting_machine_n.sv
// Directed bench for voting_machine_n: a default instance and a 2-bit-counter
// instance for saturation behaviour.
module tb_voting_machine_n;
    import vote_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       mode;
    logic [3:0] button;
    logic       clear_tally;
    logic [7:0] led;
    logic       va;
    logic       vr;
    logic [1:0] leader;
    logic       tie;
    logic       sat;

    logic       mode2;
    logic [3:0] button2;
    logic       clear2;
    logic [1:0] led2;
    logic       va2;
    logic       vr2;
    logic [1:0] leader2;
    logic       tie2;
    logic       sat2;

    int errors = 0;
    int checks = 0;

    voting_machine_n dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .mode         (mode),
        .button       (button),
        .clear_tally  (clear_tally),
        .led          (led),
        .vote_accepted(va),
        .vote_rejected(vr),
        .leader_idx   (leader),
        .tie          (tie),
        .saturated    (sat)
    );

    voting_machine_n #(.COUNT_W(2)) dut2 (
        .clock        (clock),
        .reset_n      (reset_n),
        .mode         (mode2),
        .button       (button2),
        .clear_tally  (clear2),
        .led          (led2),
        .vote_accepted(va2),
        .vote_rejected(vr2),
        .leader_idx   (leader2),
        .tie          (tie2),
        .saturated    (sat2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reads count[k] of the default instance through the tally display.
    task automatic read_count(input int k, output logic [7:0] v);
        mode   = 1'b1;
        button = 4'(1 << k);
        tick();
        v      = led;
        button = '0;
        mode   = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL reset_va: got %b expected 0", va); end
        checks++; if (vr !== 1'b0) begin errors++; $display("FAIL reset_vr: got %b expected 0", vr); end
        checks++; if (leader !== 2'd0) begin errors++; $display("FAIL reset_leader: got %0d expected 0", leader); end
        checks++; if (tie !== 1'b1) begin errors++; $display("FAIL reset_tie: got %b expected 1", tie); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_short_press();
        int va_cnt = 0;
        int led_nz = 0;
        logic [7:0] v;
        button = 4'b0100;
        repeat (9) begin tick(); if (va) va_cnt++; if (led != 0) led_nz++; end
        button = '0;
        repeat (15) begin tick(); if (va) va_cnt++; if (led != 0) led_nz++; end
        checks++; if (va_cnt !== 0) begin errors++; $display("FAIL short_va: got %0d expected 0", va_cnt); end
        checks++; if (led_nz !== 0) begin errors++; $display("FAIL short_led: got %0d nonzero cycles expected 0", led_nz); end
        read_count(2, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL short_count2: got %0d expected 0", v); end
    endtask

    task automatic test_single_vote();
        int va_cnt = 0;
        int vr_cnt = 0;
        int first = 0;
        int ones = 0;
        logic [7:0] v;
        button = 4'b0010;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (va) begin va_cnt++; if (first == 0) first = n; end
            if (vr) vr_cnt++;
            if (led == 8'hFF) ones++;
        end
        checks++; if (first !== 11) begin errors++; $display("FAIL vote_latency: got %0d expected 11", first); end
        checks++; if (va_cnt !== 1) begin errors++; $display("FAIL vote_once: got %0d expected 1", va_cnt); end
        checks++; if (vr_cnt !== 0) begin errors++; $display("FAIL vote_norej: got %0d expected 0", vr_cnt); end
        checks++; if (ones !== 10) begin errors++; $display("FAIL ack_len: got %0d expected 10", ones); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL lockout_led: got %h expected 00", led); end
        checks++; if (dut.state_q !== LOCKOUT) begin errors++; $display("FAIL held_state: got %0d expected %0d", dut.state_q, LOCKOUT); end
        checks++; if (leader !== 2'd1) begin errors++; $display("FAIL vote_leader: got %0d expected 1", leader); end
        checks++; if (tie !== 1'b0) begin errors++; $display("FAIL vote_tie: got %b expected 0", tie); end
        button = '0;
        tick();
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL release_state: got %0d expected %0d", dut.state_q, IDLE); end
        read_count(1, v);
        checks++; if (v !== 8'd1) begin errors++; $display("FAIL vote_count1: got %0d expected 1", v); end
    endtask

    task automatic test_simultaneous();
        int va_cnt = 0;
        int vr_cnt = 0;
        logic [7:0] v;
        button = 4'b1001;
        repeat (12) begin tick(); if (va) va_cnt++; if (vr) vr_cnt++; end
        button = '0;
        repeat (12) begin tick(); if (va) va_cnt++; if (vr) vr_cnt++; end
        checks++; if (va_cnt !== 1) begin errors++; $display("FAIL simul_va: got %0d expected 1", va_cnt); end
        checks++; if (vr_cnt !== 1) begin errors++; $display("FAIL simul_vr: got %0d expected 1", vr_cnt); end
        read_count(0, v);
        checks++; if (v !== 8'd1) begin errors++; $display("FAIL simul_count0: got %0d expected 1", v); end
        read_count(3, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL simul_count3: got %0d expected 0", v); end
        checks++; if (tie !== 1'b1) begin errors++; $display("FAIL simul_tie: got %b expected 1", tie); end
        checks++; if (leader !== 2'd0) begin errors++; $display("FAIL simul_leader: got %0d expected 0", leader); end
    endtask

    task automatic test_lockout_reject();
        int va_cnt = 0;
        int vr_cnt = 0;
        logic [7:0] v;
        button = 4'b0010;
        repeat (25) begin tick(); if (va) va_cnt++; end
        checks++; if (va_cnt !== 1) begin errors++; $display("FAIL lock_first_va: got %0d expected 1", va_cnt); end
        va_cnt = 0;
        button = 4'b0110;
        repeat (15) begin tick(); if (va) va_cnt++; if (vr) vr_cnt++; end
        checks++; if (va_cnt !== 0) begin errors++; $display("FAIL lock_va: got %0d expected 0", va_cnt); end
        checks++; if (vr_cnt !== 1) begin errors++; $display("FAIL lock_vr: got %0d expected 1", vr_cnt); end
        button = '0;
        repeat (2) tick();
        va_cnt = 0;
        button = 4'b0100;
        repeat (12) begin tick(); if (va) va_cnt++; end
        button = '0;
        repeat (12) tick();
        checks++; if (va_cnt !== 1) begin errors++; $display("FAIL after_lock_va: got %0d expected 1", va_cnt); end
        read_count(2, v);
        checks++; if (v !== 8'd1) begin errors++; $display("FAIL lock_count2: got %0d expected 1", v); end
        read_count(1, v);
        checks++; if (v !== 8'd2) begin errors++; $display("FAIL lock_count1: got %0d expected 2", v); end
        checks++; if (leader !== 2'd1) begin errors++; $display("FAIL lock_leader: got %0d expected 1", leader); end
        checks++; if (tie !== 1'b0) begin errors++; $display("FAIL lock_tie: got %b expected 0", tie); end
    endtask

    task automatic test_saturation();
        int va_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            button2 = 4'b0001;
            repeat (12) begin tick(); if (va2) va_cnt++; end
            button2 = '0;
            repeat (12) begin tick(); if (va2) va_cnt++; end
            if (k == 2) begin
                checks++; if (sat2 !== 1'b0) begin errors++; $display("FAIL sat_early: got %b expected 0", sat2); end
            end
        end
        checks++; if (va_cnt !== 4) begin errors++; $display("FAIL sat_va: got %0d expected 4", va_cnt); end
        checks++; if (sat2 !== 1'b1) begin errors++; $display("FAIL sat_set: got %b expected 1", sat2); end
        checks++; if (tie2 !== 1'b0) begin errors++; $display("FAIL sat_tie: got %b expected 0", tie2); end
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        checks++; if (sat2 !== 1'b1) begin errors++; $display("FAIL clear_in_vote: got %b expected 1", sat2); end
        mode2   = 1'b1;
        button2 = 4'b0001;
        tick();
        checks++; if (led2 !== 2'd3) begin errors++; $display("FAIL tally_led: got %0d expected 3", led2); end
        button2 = '0;
        tick();
        checks++; if (led2 !== 2'd3) begin errors++; $display("FAIL tally_hold: got %0d expected 3", led2); end
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        checks++; if (led2 !== 2'd0) begin errors++; $display("FAIL clear_led: got %0d expected 0", led2); end
        checks++; if (sat2 !== 1'b0) begin errors++; $display("FAIL clear_sat: got %b expected 0", sat2); end
        tick();
        checks++; if (tie2 !== 1'b1) begin errors++; $display("FAIL clear_tie: got %b expected 1", tie2); end
        checks++; if (leader2 !== 2'd0) begin errors++; $display("FAIL clear_leader: got %0d expected 0", leader2); end
        mode2 = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        button = 4'b0001;
        repeat (13) tick();
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL pre_reset_ack: got %h expected FF", led); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL async_led: got %h expected 00", led); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL async_state: got %0d expected %0d", dut.state_q, IDLE); end
        checks++; if (tie !== 1'b1) begin errors++; $display("FAIL async_tie: got %b expected 1", tie); end
        button = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        read_count(0, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL post_reset_count0: got %0d expected 0", v); end
        read_count(1, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL post_reset_count1: got %0d expected 0", v); end
    endtask

    initial begin
        reset_n     = 1'b0;
        mode        = 1'b0;
        button      = '0;
        clear_tally = 1'b0;
        mode2       = 1'b0;
        button2     = '0;
        clear2      = 1'b0;
        test_reset();
        test_short_press();
        test_single_vote();
        test_simultaneous();
        test_lockout_reject();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/voting_machine_n.md
Name: voting_machine_n

Overview:
Parametrised N-candidate voting machine, next generation of the 4-button voting machine. It provides per-button debounce, one vote per press session with a release lockout, saturating vote counters, and a tally display mode. It also adds a registered leader/tie output and an explicit tally clear. It is the top of the voting subsystem and drives the LED bank directly.

Parameters:
NUM_CAND, 4, number of candidates/buttons (2..16)
DEBOUNCE_CYCLES, 10, consecutive high cycles before a press counts (>=2)
COUNT_W, 8, width of each vote counter and of led
ACK_CYCLES, 10, cycles led shows all-ones after an accepted vote
IDX_W, $clog2(NUM_CAND), width of candidate index outputs

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
mode  in  1  0 = vote, 1 = tally
button  in  NUM_CAND  raw candidate buttons, bit i = candidate i
clear_tally  in  1  synchronous clear of all counters, honoured in tally mode only
led  out  COUNT_W  LED bank
vote_accepted  out  1  one-cycle pulse when a vote is recorded
vote_rejected  out  1  one-cycle pulse when a qualified press is discarded
leader_idx  out  IDX_W  index of the highest-count candidate
tie  out  1  two or more candidates share the maximum count
saturated  out  1  sticky; set when any counter sits at max and receives another vote

Behaviour:
- Reset (async assert, sync release) clears every register: led=0, vote_accepted=0, vote_rejected=0, leader_idx=0, tie=1 (all counts equal), saturated=0, counters=0, FSM=IDLE.
- Debounce, per channel:
  - cnt increments while button[i]=1 and saturates at DEBOUNCE_CYCLES+1. It clears when button[i]=0.
  - qual[i] pulses for exactly one cycle on the cycle cnt==DEBOUNCE_CYCLES, giving one pulse per press however long the button is held.
  - A press qualifies DEBOUNCE_CYCLES+1 cycles after the first high sample.
- Vote FSM states are IDLE, ACK and LOCKOUT.
  - IDLE, mode=0, any qual:
    - Candidate k = lowest index with qual set.
    - count[k] increments, saturating at 2^COUNT_W-1.
    - vote_accepted pulses on the next cycle.
    - If any other qual bit is set in the same cycle, vote_rejected pulses as well.
    - Next state is ACK.
  - ACK:
    - led=all-ones for ACK_CYCLES cycles. Any qual in ACK gives vote_rejected and no count.
    - At the end of ACK: go to LOCKOUT if any button is high, else IDLE.
  - LOCKOUT: every qual gives vote_rejected. Go to IDLE on the first cycle with all buttons low.
  - IDLE, mode=0, no qual: led=0.
  - mode=1 (any state): FSM is forced to IDLE next cycle and the ACK timer is cleared. qual pulses are ignored and neither counted nor rejected.
- Tally display (mode=1):
  - led <= count of the lowest-index raw button high. This is raw, with no debounce.
  - If no button is high, led holds its value.
  - led update latency is 1 cycle.
- clear_tally with mode=1: all counts=0 and saturated=0 next cycle; led=0. With mode=0 it is ignored.
- Saturation: an increment at max leaves the count at max, still pulses vote_accepted, and sets saturated.
- Leader/tie:
  - Registered, 1-cycle latency after any count change.
  - leader_idx = lowest index holding the maximum count.
  - tie = 1 when the maximum is held by at least 2 candidates; this includes the all-zero case.
- Reset mid-ACK or mid-LOCKOUT returns immediately to the reset values.

Decomposition:
- Shared package vote_pkg holds:
  - typedef vote_state_t {IDLE, ACK, LOCKOUT}
  - constants MODE_VOTE=1'b0 and MODE_TALLY=1'b1
  - a function lowest_set_idx(vector) used for candidate selection and leader selection
- One sub-module, vote_debounce (params DEBOUNCE_CYCLES; ports clock, reset_n, button, qual), instantiated NUM_CAND times via generate.
- Counters, FSM, display mux and leader logic stay in voting_machine_n.

Test Plan:
- Reset, then hold button[2] high for 9 cycles, then release -> no vote_accepted, count[2]=0, led=0.
- mode=0, hold button[1] for 30 cycles -> exactly one vote_accepted, 11 cycles after the first high. led=0xFF for 10 cycles. FSM goes to LOCKOUT until release. count[1]=1, leader_idx=1, tie=0.
- button[0] and button[3] rise on the same cycle -> count[0]=1, count[3]=0, vote_accepted and vote_rejected both pulse once.
- Press button[2] while in LOCKOUT from a held button[1] -> vote_rejected, count[2] unchanged. After all buttons are released, a press of button[2] is accepted.
- COUNT_W=2: 4 votes for candidate 0 -> count[0]=3, saturated=1. mode=1 plus press button[0] -> led=3. clear_tally -> led=0, saturated=0, tie=1.
- Assert reset_n low mid-ACK, asynchronously between edges -> led=0 and the FSM is in IDLE without waiting for a clock edge. Counters are 0 after release.
